reg_status_file: RTL and testbench

//  Architectural register file plus rename-status table; final consumer of the ROB commit broadcast.

---
 rtl/reg_status_file.sv | 123 ++++++++++++
 tb/tb_reg_status_file.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_status_file.sv
// Architectural register file with rename-status (busy/tag) table.
// Dispatch renames a destination to a ROB tag. A ROB commit writes the value and
// frees the register only if the register still maps to that tag. Both read
// ports are combinational and forward a same-cycle freeing commit.
module reg_status_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned XLEN    = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             roll_back,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [TAG_W-1:0] issue_entry,
    input  logic             rob_commit,
    input  logic             commit_wr_en,
    input  logic [4:0]       rob_des_commit,
    input  logic [TAG_W-1:0] rob_entry_commit,
    input  logic [XLEN-1:0]  rob_result_out,
    input  logic [4:0]       rs1_addr,
    output logic [XLEN-1:0]  rs1_value,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs2_value,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag
);

    localparam int unsigned AW = 5;

    logic [XLEN-1:0]  value_q [REG_NUM];
    logic [XLEN-1:0]  value_d [REG_NUM];
    logic [TAG_W-1:0] tag_q   [REG_NUM];
    logic [TAG_W-1:0] tag_d   [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic commit_ok;
    logic commit_clr;
    logic issue_ok;
    logic flush_ok;

    // Qualified strobes; everything is gated by rdy_in so a pause freezes state.
    always_comb begin
        commit_ok  = rdy_in && rob_commit && commit_wr_en && (rob_des_commit != '0);
        commit_clr = commit_ok && busy_q[rob_des_commit]
                     && (tag_q[rob_des_commit] == rob_entry_commit);
        issue_ok   = rdy_in && issue_valid && !roll_back && (issue_rd != '0);
        flush_ok   = rdy_in && roll_back;
    end

    // Next state: commit writes value, flush/commit free, issue renames last so it wins.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (commit_ok && (rob_des_commit == AW'(i))) begin
                value_d[i] = rob_result_out;
            end
            if (flush_ok) begin
                busy_d[i] = 1'b0;
            end else if (commit_clr && (rob_des_commit == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (issue_ok && (issue_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = issue_entry;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    // Read port 1: x0 reads zero, a freeing commit to the same register is forwarded.
    always_comb begin
        rs1_value = '0;
        rs1_busy  = 1'b0;
        rs1_tag   = '0;
        if (rs1_addr != '0) begin
            if (commit_clr && (rob_des_commit == rs1_addr)) begin
                rs1_value = rob_result_out;
            end else begin
                rs1_value = value_q[rs1_addr];
                rs1_busy  = busy_q[rs1_addr];
                rs1_tag   = tag_q[rs1_addr];
            end
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        rs2_value = '0;
        rs2_busy  = 1'b0;
        rs2_tag   = '0;
        if (rs2_addr != '0) begin
            if (commit_clr && (rob_des_commit == rs2_addr)) begin
                rs2_value = rob_result_out;
            end else begin
                rs2_value = value_q[rs2_addr];
                rs2_busy  = busy_q[rs2_addr];
                rs2_tag   = tag_q[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: architectural model plus directed and randomized stimulus.
module tb_reg_status_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_entry;
    logic        rob_commit;
    logic        commit_wr_en;
    logic [4:0]  rob_des_commit;
    logic [4:0]  rob_entry_commit;
    logic [31:0] rob_result_out;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_value;
    logic        rs1_busy;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_value;
    logic        rs2_busy;
    logic [4:0]  rs2_tag;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // Architectural model state.
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [4:0]  m_tag  [32];

    reg_status_file #(.REG_NUM(32), .TAG_W(5), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_entry(issue_entry),
        .rob_commit(rob_commit), .commit_wr_en(commit_wr_en),
        .rob_des_commit(rob_des_commit), .rob_entry_commit(rob_entry_commit),
        .rob_result_out(rob_result_out),
        .rs1_addr(rs1_addr), .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_addr(rs2_addr), .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update: follows the architectural rules on each clock edge.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else if (rdy_in) begin
            bit frees;
            frees = 0;
            if (rob_commit && commit_wr_en && rob_des_commit != 0) begin
                frees = m_busy[rob_des_commit] && (m_tag[rob_des_commit] == rob_entry_commit);
                m_val[rob_des_commit] = rob_result_out;
            end
            if (roll_back) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (frees) m_busy[rob_des_commit] = 0;
                if (issue_valid && issue_rd != 0) begin
                    m_busy[issue_rd] = 1;
                    m_tag[issue_rd]  = issue_entry;
                end
            end
        end
    end

    // Expected read result for an address given model state and current inputs.
    task automatic exp_read(input logic [4:0] a, output logic [31:0] v, output bit b,
                            output logic [4:0] t);
        v = 0; b = 0; t = 0;
        if (a != 0) begin
            if (rdy_in && rob_commit && commit_wr_en && rob_des_commit == a
                && m_busy[a] && m_tag[a] == rob_entry_commit) begin
                v = rob_result_out;
            end else begin
                v = m_val[a]; b = m_busy[a]; t = m_tag[a];
            end
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk_in) begin
        if (check_en && rst_in) begin
            logic [31:0] ev; bit eb; logic [4:0] et;
            exp_read(rs1_addr, ev, eb, et);
            chk("rs1_value", rs1_value, ev);
            chk("rs1_busy", 32'(rs1_busy), 32'(eb));
            if (eb) chk("rs1_tag", 32'(rs1_tag), 32'(et));
            exp_read(rs2_addr, ev, eb, et);
            chk("rs2_value", rs2_value, ev);
            chk("rs2_busy", 32'(rs2_busy), 32'(eb));
            if (eb) chk("rs2_tag", 32'(rs2_tag), 32'(et));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1; roll_back = 0; issue_valid = 0; rob_commit = 0; commit_wr_en = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [4:0] e);
        issue_valid = 1; issue_rd = rd; issue_entry = e;
        tick();
        idle();
    endtask

    task automatic set_commit(input logic [4:0] d, input logic [4:0] e, input logic [31:0] r);
        rob_commit = 1; commit_wr_en = 1; rob_des_commit = d; rob_entry_commit = e;
        rob_result_out = r;
    endtask

    initial begin
        rst_in = 0; idle();
        issue_rd = 0; issue_entry = 0; rob_des_commit = 0; rob_entry_commit = 0;
        rob_result_out = 0; rs1_addr = 5; rs2_addr = 0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1;
        check_en = 1;

        // 1: reset state then rename
        @(negedge clk_in);
        chk("t1_reset_value", rs1_value, 32'h0);
        chk("t1_reset_busy", 32'(rs1_busy), 32'h0);
        tick();
        do_issue(5, 3);
        @(negedge clk_in);
        chk("t1_busy", 32'(rs1_busy), 32'h1);
        chk("t1_tag", 32'(rs1_tag), 32'h3);

        // 2: commit with bypass then registered
        tick();
        set_commit(5, 3, 32'hDEAD_BEEF);
        @(negedge clk_in);
        chk("t2_bypass_value", rs1_value, 32'hDEAD_BEEF);
        chk("t2_bypass_busy", 32'(rs1_busy), 32'h0);
        tick();
        idle();
        @(negedge clk_in);
        chk("t2_state_value", rs1_value, 32'hDEAD_BEEF);
        chk("t2_state_busy", 32'(rs1_busy), 32'h0);

        // 3: stale commit does not free a newer rename
        tick();
        do_issue(5, 3);
        do_issue(5, 7);
        set_commit(5, 3, 32'h11);
        tick();
        idle();
        @(negedge clk_in);
        chk("t3_value", rs1_value, 32'h11);
        chk("t3_busy", 32'(rs1_busy), 32'h1);
        chk("t3_tag", 32'(rs1_tag), 32'h7);

        // 4: same-cycle issue and commit on one register
        tick();
        rs2_addr = 6;
        do_issue(6, 4);
        issue_valid = 1; issue_rd = 6; issue_entry = 9;
        set_commit(6, 4, 32'h22);
        tick();
        idle();
        @(negedge clk_in);
        chk("t4_value", rs2_value, 32'h22);
        chk("t4_busy", 32'(rs2_busy), 32'h1);
        chk("t4_tag", 32'(rs2_tag), 32'h9);

        // 5: roll_back clears busy, drops issue, keeps commit value
        tick();
        for (int i = 1; i <= 4; i++) do_issue(5'(i), 5'(i + 10));
        roll_back = 1; issue_valid = 1; issue_rd = 8; issue_entry = 10;
        set_commit(9, 0, 32'h99);
        tick();
        idle();
        for (int i = 1; i <= 9; i++) begin
            rs1_addr = 5'(i);
            #1 chk("t5_busy_cleared", 32'(rs1_busy), 32'h0);
        end
        rs1_addr = 9;
        #1 chk("t5_commit_value", rs1_value, 32'h99);
        issue_valid = 1; issue_rd = 0; issue_entry = 5;
        set_commit(0, 0, 32'hFF);
        rs1_addr = 0;
        tick();
        idle();
        @(negedge clk_in);
        chk("t5_x0_value", rs1_value, 32'h0);
        chk("t5_x0_busy", 32'(rs1_busy), 32'h0);

        // 6: pause blocks everything, then async reset pulse
        tick();
        do_issue(2, 12);
        rdy_in = 0; roll_back = 1;
        issue_valid = 1; issue_rd = 3; issue_entry = 6;
        set_commit(2, 12, 32'h33);
        rs1_addr = 2; rs2_addr = 3;
        @(negedge clk_in);
        chk("t6_pause_busy", 32'(rs1_busy), 32'h1);
        chk("t6_pause_value", rs1_value, 32'h0);
        tick();
        idle();
        @(negedge clk_in);
        chk("t6_hold_busy", 32'(rs1_busy), 32'h1);
        chk("t6_hold_tag", 32'(rs1_tag), 32'd12);
        chk("t6_hold_x3", 32'(rs2_busy), 32'h0);
        tick();
        rs2_addr = 6;
        #2 rst_in = 0;
        #1;
        chk("t6_rst_busy", 32'(rs1_busy), 32'h0);
        chk("t6_rst_tag", 32'(rs1_tag), 32'h0);
        chk("t6_rst_value", rs2_value, 32'h0);
        rst_in = 1;

        // Randomized traffic on a small register window, checked by the model.
        for (int c = 0; c < 400; c++) begin
            tick();
            rdy_in = ($urandom_range(0, 9) != 0);
            roll_back = ($urandom_range(0, 19) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7));
            issue_entry = 5'($urandom);
            rob_commit = 1'($urandom_range(0, 1));
            commit_wr_en = ($urandom_range(0, 3) != 0);
            rob_des_commit = 5'($urandom_range(0, 7));
            rob_entry_commit = ($urandom_range(0, 3) != 0) ? m_tag[rob_des_commit] : 5'($urandom);
            rob_result_out = $urandom;
            rs1_addr = ($urandom_range(0, 1) != 0) ? rob_des_commit : 5'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 1) != 0) ? issue_rd : 5'($urandom_range(0, 7));
        end
        tick();
        idle();
        @(negedge clk_in);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
